// File: rtl/regfile_sb.sv
// Parametrised NUM_RD-read / 1-write integer register file with hardwired-zero x0 and a per-register busy scoreboard.
// Optional write-through forwarding of the writeback port is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned NREG   = 32,
  parameter  int unsigned NUM_RD = 2,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wb_valid,
  input  logic [AW-1:0]            wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_addr,
  output logic                     iss_stall,
  output logic [NREG-1:0]          busy_vec
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic            wb_en;

  assign wb_en = wb_valid && (wb_addr != '0);

  // regs[0] is cleared by reset and never written, so it permanently holds zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // A releasing writeback lets a same-register issue through; the new reservation wins.
  assign iss_stall = iss_valid && (iss_addr != '0) && busy[iss_addr] &&
                     !(wb_valid && (wb_addr == iss_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (iss_valid && !iss_stall && (iss_addr == AW'(r)))
          busy[r] <= 1'b1;
        else if (wb_valid && (wb_addr == AW'(r)))
          busy[r] <= 1'b0;
      end
    end
  end

  assign busy_vec = busy;

  logic [AW-1:0] ra;
`ifdef REGFILE_BYPASS_EN
  logic          fwd;
`endif

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
`ifdef REGFILE_BYPASS_EN
    fwd     = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      fwd = wb_en && (wb_addr == ra);
      if (fwd) begin
        rd_data[i*XLEN +: XLEN] = wb_data;
        rd_busy[i]              = 1'b0;
      end else begin
        rd_data[i*XLEN +: XLEN] = (ra == '0) ? '0 : regs[ra];
        rd_busy[i]              = busy[ra];
      end
`else
      rd_data[i*XLEN +: XLEN] = (ra == '0) ? '0 : regs[ra];
      rd_busy[i]              = busy[ra];
`endif
    end
  end

endmodule
